rrg_sequencer: RTL and testbench

Program sequencer for the real-time ramp generator. It holds a small table of ramp steps, each made of Yset, Rset, RIset, ROset and a dwell time. It plays the steps in order by driving the generator's multiplexed command/data register interface (reg_control, reg_0..reg_3). It sits between the host bus and the generator and runs on the generator's slow clock, so the generator sees one command per clk_slow cycle.

---
 rtl/rrg_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_rrg_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rrg_sequencer.sv
// rrg_sequencer: plays a table of ramp steps to the ramp generator, issuing one
// command per clk_slow cycle on the multiplexed reg_control/reg_0..reg_3 interface.
// Ports:
//   clk_slow, nReset (synchronous, active-low)
//   start/abort/loop_en/num_steps : playback control
//   prog_we/prog_addr/prog_sel/prog_data : program table write port (idle only)
//   trig : external step-advance trigger (optional build only)
//   reg_control, reg_0..reg_3 : command and data to the generator
//   busy, done, cur_step, prog_err : status
// Optional build macro: RRG_SEQ_TRIGGER_EN (wait for trig after each dwell).
module rrg_sequencer #(
  parameter int unsigned NR_STEPS   = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DWELL_W    = 32,
  parameter logic [7:0]  WR_DATASET = 8'd0
) (
  input  logic              clk_slow,
  input  logic              nReset,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [ADDR_W:0]   num_steps,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [2:0]        prog_sel,
  input  logic [63:0]       prog_data,
  input  logic              trig,
  output logic [15:0]       reg_control,
  output logic [15:0]       reg_0,
  output logic [15:0]       reg_1,
  output logic [15:0]       reg_2,
  output logic [15:0]       reg_3,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_step,
  output logic              prog_err
);

  localparam logic [7:0] CMD_IDLE   = 8'd0;
  localparam logic [7:0] CMD_YSET   = 8'd1;
  localparam logic [7:0] CMD_RSET   = 8'd2;
  localparam logic [7:0] CMD_RISET  = 8'd3;
  localparam logic [7:0] CMD_ROSET  = 8'd4;
  localparam logic [7:0] CMD_UPDATE = 8'd5;
  localparam logic [7:0] CMD_HALT   = 8'd9;

  localparam logic [ADDR_W:0] NR_STEPS_W = (ADDR_W+1)'(NR_STEPS);

  typedef enum logic [3:0] {
    S_IDLE, S_W_Y, S_W_R, S_W_RI, S_W_RO, S_UPD, S_GAP, S_DWELL,
`ifdef RRG_SEQ_TRIGGER_EN
    S_WAIT_TRIG,
`endif
    S_NEXT, S_HALT
  } state_t;

  // State entered once the dwell time has elapsed
`ifdef RRG_SEQ_TRIGGER_EN
  localparam state_t S_AFTER_DWELL = S_WAIT_TRIG;
`else
  localparam state_t S_AFTER_DWELL = S_NEXT;
  logic unused_trig;
  assign unused_trig = trig;
`endif

  // Program table (not reset)
  logic [63:0]        yset_mem  [NR_STEPS];
  logic [63:0]        rset_mem  [NR_STEPS];
  logic [63:0]        riset_mem [NR_STEPS];
  logic [63:0]        roset_mem [NR_STEPS];
  logic [DWELL_W-1:0] dwell_mem [NR_STEPS];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_step_q, cur_step_d;
  logic [ADDR_W:0]     eff_q, eff_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [15:0]         ctrl_q, ctrl_d;
  logic [63:0]         data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                prog_err_q, prog_err_d;

  logic [ADDR_W:0]     eff_c;
  logic                last_c;
  logic [7:0]          cmd_c;

  assign eff_c  = (num_steps > NR_STEPS_W) ? NR_STEPS_W : num_steps;
  assign last_c = (ADDR_W+1)'({1'b0, cur_step_q}) + (ADDR_W+1)'(1) >= eff_q;

  // Table write port: accepted only while idle with a valid field select
  always_ff @(posedge clk_slow) begin
    if (prog_we && state_q == S_IDLE) begin
      case (prog_sel)
        3'd0:    yset_mem[prog_addr]  <= prog_data;
        3'd1:    rset_mem[prog_addr]  <= prog_data;
        3'd2:    riset_mem[prog_addr] <= prog_data;
        3'd3:    roset_mem[prog_addr] <= prog_data;
        3'd4:    dwell_mem[prog_addr] <= prog_data[DWELL_W-1:0];
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_slow) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      cur_step_q <= '0;
      eff_q      <= '0;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_step_q <= cur_step_d;
      eff_q      <= eff_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      prog_err_q <= prog_err_d;
    end
  end

  // Next state, then registered outputs decoded from the next state so each
  // command appears in the same cycle the FSM occupies its state.
  always_comb begin
    state_d    = state_q;
    cur_step_d = cur_step_q;
    eff_d      = eff_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    prog_err_d = prog_we && (state_q != S_IDLE || prog_sel > 3'd4);
    cmd_c      = CMD_IDLE;
    data_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          eff_d      = eff_c;
          cur_step_d = '0;
          if (eff_c == '0) done_d  = 1'b1;
          else             state_d = S_W_Y;
        end
      end
      S_W_Y:  state_d = S_W_R;
      S_W_R:  state_d = S_W_RI;
      S_W_RI: state_d = S_W_RO;
      S_W_RO: state_d = S_UPD;
      S_UPD:  state_d = S_GAP;
      S_GAP: begin
        // Counter is loaded here; dwell 0 or 1 skips DWELL entirely
        cnt_d   = dwell_mem[cur_step_q];
        state_d = (dwell_mem[cur_step_q] <= DWELL_W'(1)) ? S_AFTER_DWELL : S_DWELL;
      end
      S_DWELL: begin
        cnt_d = cnt_q - DWELL_W'(1);
        if (cnt_q <= DWELL_W'(2)) state_d = S_AFTER_DWELL;
      end
`ifdef RRG_SEQ_TRIGGER_EN
      S_WAIT_TRIG: if (trig) state_d = S_NEXT;
`endif
      S_NEXT: begin
        if (!last_c) begin
          cur_step_d = cur_step_q + ADDR_W'(1);
          state_d    = S_W_Y;
        end else if (loop_en) begin
          cur_step_d = '0;
          state_d    = S_W_Y;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any playback progress; already halting is left alone
    if (abort && state_q != S_IDLE && state_q != S_HALT) begin
      state_d    = S_HALT;
      cur_step_d = cur_step_q;
      done_d     = 1'b0;
    end

    case (state_d)
      S_W_Y:   begin cmd_c = CMD_YSET;  data_d = yset_mem[cur_step_d];  end
      S_W_R:   begin cmd_c = CMD_RSET;  data_d = rset_mem[cur_step_d];  end
      S_W_RI:  begin cmd_c = CMD_RISET; data_d = riset_mem[cur_step_d]; end
      S_W_RO:  begin cmd_c = CMD_ROSET; data_d = roset_mem[cur_step_d]; end
      S_UPD:   cmd_c = CMD_UPDATE;
      S_HALT:  cmd_c = CMD_HALT;
      default: cmd_c = CMD_IDLE;
    endcase

    ctrl_d = {WR_DATASET, cmd_c};
    busy_d = (state_d != S_IDLE);
  end

  assign reg_control = ctrl_q;
  assign reg_0       = data_q[15:0];
  assign reg_1       = data_q[31:16];
  assign reg_2       = data_q[47:32];
  assign reg_3       = data_q[63:48];
  assign busy        = busy_q;
  assign done        = done_q;
  assign cur_step    = cur_step_q;
  assign prog_err    = prog_err_q;

endmodule

// File: tb/tb_rrg_sequencer.sv
// Self-checking bench for rrg_sequencer (default build).
module tb_rrg_sequencer;

  localparam int unsigned ADDR_W = 4;

  logic              clk_slow = 1'b0;
  logic              nReset, start, abort, loop_en, prog_we, trig;
  logic [ADDR_W:0]   num_steps;
  logic [ADDR_W-1:0] prog_addr;
  logic [2:0]        prog_sel;
  logic [63:0]       prog_data;
  logic [15:0]       reg_control, reg_0, reg_1, reg_2, reg_3;
  logic              busy, done, prog_err;
  logic [ADDR_W-1:0] cur_step;

  int n_chk  = 0;
  int n_fail = 0;

  rrg_sequencer dut (
    .clk_slow(clk_slow), .nReset(nReset), .start(start), .abort(abort),
    .loop_en(loop_en), .num_steps(num_steps), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_sel(prog_sel), .prog_data(prog_data),
    .trig(trig), .reg_control(reg_control), .reg_0(reg_0), .reg_1(reg_1),
    .reg_2(reg_2), .reg_3(reg_3), .busy(busy), .done(done),
    .cur_step(cur_step), .prog_err(prog_err)
  );

  always #5 clk_slow = ~clk_slow;

  typedef struct {
    logic [15:0] ctrl;
    logic [63:0] data;
    logic        busy;
    logic        done;
  } vec_t;

  localparam logic [63:0] T1_Y  = 64'h1000_0000_0000_0000;
  localparam logic [63:0] T1_R  = 64'h0000_0010_0000_0000;
  localparam logic [63:0] T1_RI = 64'h0000_0001_0000_0000;
  localparam logic [63:0] T1_RO = 64'h0000_0001_0000_0000;

  function automatic logic [63:0] dout();
    return {reg_3, reg_2, reg_1, reg_0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_slow);
  endtask

  task automatic wr(input int row, input int sel, input logic [63:0] d);
    prog_we   = 1'b1;
    prog_addr = ADDR_W'(row);
    prog_sel  = 3'(sel);
    prog_data = d;
    cyc();
    prog_we   = 1'b0;
  endtask

  task automatic set_step(input int row, input logic [63:0] y, input logic [63:0] r,
                          input logic [63:0] ri, input logic [63:0] ro, input logic [63:0] dw);
    wr(row, 0, y); wr(row, 1, r); wr(row, 2, ri); wr(row, 3, ro); wr(row, 4, dw);
  endtask

  task automatic go(input int n, input logic lp);
    num_steps = (ADDR_W+1)'(n);
    loop_en   = lp;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 300) begin cyc(); k++; end
    chk(name, 64'(busy), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v1 [18];
    int   wy_cyc [$];
    int   wy_stp [$];
    int   exp_cyc [5] = '{1, 8, 19, 27, 34};
    int   exp_stp [5] = '{0, 1, 2, 0, 1};
    int   cnt, dn, k;
    logic found;

    nReset = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0; trig = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_sel = '0; prog_data = '0; num_steps = '0;
    repeat (3) cyc();
    nReset = 1'b1;
    cyc();

    // Reset state
    chk("rst ctrl", 64'(reg_control), 64'h0);
    chk("rst data", dout(), 64'h0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst step", 64'(cur_step), 64'd0);
    chk("rst perr", 64'(prog_err), 64'd0);

    // Single step, dwell 10: table of per-cycle expectations
    for (int i = 0; i < 18; i++) v1[i] = '{16'h0, 64'h0, (i < 16), (i == 16)};
    v1[0].ctrl = 16'h1; v1[0].data = T1_Y;
    v1[1].ctrl = 16'h2; v1[1].data = T1_R;
    v1[2].ctrl = 16'h3; v1[2].data = T1_RI;
    v1[3].ctrl = 16'h4; v1[3].data = T1_RO;
    v1[4].ctrl = 16'h5;
    set_step(0, T1_Y, T1_R, T1_RI, T1_RO, 64'd10);
    go(1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("t1[%0d] ctrl", i), 64'(reg_control), 64'(v1[i].ctrl));
      chk($sformatf("t1[%0d] data", i), dout(), v1[i].data);
      chk($sformatf("t1[%0d] busy", i), 64'(busy), 64'(v1[i].busy));
      chk($sformatf("t1[%0d] done", i), 64'(done), 64'(v1[i].done));
      chk($sformatf("t1[%0d] step", i), 64'(cur_step), 64'd0);
      cyc();
    end

    // Three steps, dwells 0/5/2, looping: W_Y every 7, 11, 8 cycles
    set_step(0, 64'hA000_0000_0000_0001, 64'h0, 64'h0, 64'h0, 64'd0);
    set_step(1, 64'hA000_0000_0000_0002, 64'h0, 64'h0, 64'h0, 64'd5);
    set_step(2, 64'hA000_0000_0000_0003, 64'h0, 64'h0, 64'h0, 64'd2);
    go(3, 1'b1);
    dn = 0;
    for (int c = 1; c <= 40; c++) begin
      if (reg_control == 16'h1) begin wy_cyc.push_back(c); wy_stp.push_back(int'(cur_step)); end
      if (done) dn++;
      if (c < 40) cyc();
    end
    chk("t2 wy count", 64'(wy_cyc.size()), 64'd5);
    for (int i = 0; i < 5 && i < wy_cyc.size(); i++) begin
      chk($sformatf("t2 wy[%0d] cycle", i), 64'(wy_cyc[i]), 64'(exp_cyc[i]));
      chk($sformatf("t2 wy[%0d] step", i), 64'(wy_stp[i]), 64'(exp_stp[i]));
    end
    chk("t2 no done", 64'(dn), 64'd0);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t2 halt ctrl", 64'(reg_control), 64'h9);
    chk("t2 halt busy", 64'(busy), 64'd1);
    cyc();
    chk("t2 post ctrl", 64'(reg_control), 64'h0);
    chk("t2 post busy", 64'(busy), 64'd0);

    // Abort during W_RI of step 1
    go(3, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (reg_control == 16'h3 && cur_step == ADDR_W'(1)) found = 1'b1;
      else cyc();
    end
    chk("t3 reach W_RI step1", 64'(found), 64'd1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t3 halt ctrl", 64'(reg_control), 64'h9);
    chk("t3 halt data", dout(), 64'h0);
    chk("t3 halt busy", 64'(busy), 64'd1);
    chk("t3 halt done", 64'(done), 64'd0);
    cyc();
    chk("t3 idle ctrl", 64'(reg_control), 64'h0);
    chk("t3 idle busy", 64'(busy), 64'd0);
    cnt = 0; dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (reg_control == 16'h5) cnt++;
      if (done) dn++;
      cyc();
    end
    chk("t3 no update", 64'(cnt), 64'd0);
    chk("t3 no done", 64'(dn), 64'd0);

    // prog_we while busy, prog_sel=6 while idle
    go(1, 1'b0);
    wr(0, 0, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("t4 busy perr", 64'(prog_err), 64'd1);
    cyc();
    chk("t4 busy perr clr", 64'(prog_err), 64'd0);
    wait_idle("t4 idle1");
    wr(0, 6, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("t4 sel6 perr", 64'(prog_err), 64'd1);
    cyc();
    chk("t4 sel6 perr clr", 64'(prog_err), 64'd0);
    go(1, 1'b0);
    chk("t4 replay ctrl", 64'(reg_control), 64'h1);
    chk("t4 replay data", dout(), 64'hA000_0000_0000_0001);
    wait_idle("t4 idle2");
    cyc();

    // num_steps = 0: done next cycle, no commands
    go(0, 1'b0);
    chk("t5 zero done", 64'(done), 64'd1);
    chk("t5 zero busy", 64'(busy), 64'd0);
    chk("t5 zero ctrl", 64'(reg_control), 64'h0);
    cyc();
    chk("t5 zero done clr", 64'(done), 64'd0);
    chk("t5 zero ctrl2", 64'(reg_control), 64'h0);

    // start and abort together while idle: no effect
    num_steps = 5'd1; start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    chk("t6 sa busy", 64'(busy), 64'd0);
    chk("t6 sa ctrl", 64'(reg_control), 64'h0);
    chk("t6 sa done", 64'(done), 64'd0);

    // num_steps above NR_STEPS clamps to 16 steps
    for (int r = 3; r < 16; r++) wr(r, 4, 64'd0);
    go(20, 1'b0);
    cnt = 0; k = 0; found = 1'b0;
    while (!found && k < 400) begin
      if (reg_control == 16'h1) cnt++;
      if (done) found = 1'b1;
      else begin cyc(); k++; end
    end
    chk("t7 done seen", 64'(found), 64'd1);
    chk("t7 steps played", 64'(cnt), 64'd16);
    chk("t7 last step", 64'(cur_step), 64'd15);

    // Reset mid-playback: outputs clear at once, no HALT afterwards
    cyc();
    go(2, 1'b0);
    cyc(); cyc();
    nReset = 1'b0; cyc();
    chk("t8 rst ctrl", 64'(reg_control), 64'h0);
    chk("t8 rst busy", 64'(busy), 64'd0);
    chk("t8 rst step", 64'(cur_step), 64'd0);
    nReset = 1'b1; cyc();
    chk("t8 post ctrl", 64'(reg_control), 64'h0);
    chk("t8 post busy", 64'(busy), 64'd0);
    cyc();
    chk("t8 post ctrl2", 64'(reg_control), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
